text_link_ctrl: RTL and testbench
=================================

// Module: text_link_ctrl
// PURPOSE
//  Sequencer for the text link: source -> compress -> encrypt -> Hamming -> BPSK -> channel -> demod -> decode -> decrypt -> decompress -> sink.
//  Loads the cipher key and raises init_done. Moves one character per frame through the chain.
//  Retransmits on a fatal Hamming error or a channel timeout. Hands each decoded character to the sink.
//  Sits in text_top beside the datapath; it drives only the control pins, never data.
// PARAMETERS
//  KEY        8'd123  cipher key, presented on key with key_ld
//  ENC_LAT    2       cycles from fetch accept to valid encoder/modulator output (>=1)
//  DEC_LAT    2       cycles from chan_done to valid Hamming decoder flags (>=1)
//  TIMEOUT    255     max wait cycles in KEYLOAD or XMIT (>=1)
//  MAX_RETRY  3       retransmissions allowed per character (0 = none)
//  CNT_W      16      statistics counter width
// PORTS
//  clk            in   1      system clock, all logic on rising edge
//  reset          in   1      asynchronous, active-low reset
//  enable         in   1      level: run link; low aborts (see BEHAVIOUR)
//  key            out  8      cipher key (= KEY whenever key_ld=1, else 0)
//  key_ld         out  1      one-cycle key load strobe to encrypt/decrypt
//  crypto_ready   in   1      encrypt/decrypt have accepted the key
//  init_done      out  1      key loaded; gates get_text/encrypt/decrypt/sink
//  src_req        out  1      request next character from get_text
//  src_valid      in   1      character present on datapath; accepted when src_req & src_valid
//  src_last       in   1      qualifies src_valid: final character of message
//  tx_start       out  1      one-cycle strobe: channel takes mod_out
//  chan_done      in   1      channel output valid
//  err_corrected  in   1      Hamming decoder flag
//  err_fatal      in   1      Hamming decoder flag
//  sink_valid     out  1      decoded character valid for sink
//  sink_ready     in   1      sink accepts; handshake = sink_valid & sink_ready
//  busy           out  1      state not IDLE/DONE/FAIL
//  done           out  1      sticky: message delivered
//  link_fail      out  1      sticky: retries or KEYLOAD timeout exhausted
//  state_o        out  4      current state code (debug)
// BEHAVIOUR
//  Reset: every output 0, state IDLE, all timers/counters 0. Reset mid-frame aborts immediately; no strobe is emitted.
//  States (codes 0-8): IDLE, KEYLOAD, FETCH, ENCODE, XMIT, DECODE, DELIVER, DONE, FAIL.
//  IDLE: enable=1 -> KEYLOAD. key_ld=1 for exactly the first KEYLOAD cycle.
//  KEYLOAD: crypto_ready=1 -> FETCH and init_done<=1. init_done holds until IDLE or reset.
//    No crypto_ready after TIMEOUT cycles -> FAIL.
//  FETCH: src_req=1 until the accept cycle. On accept: latch src_last, retry_cnt<=0, -> ENCODE.
//  ENCODE: wait ENC_LAT cycles -> XMIT. tx_start=1 on the XMIT entry cycle; timer cleared.
//  XMIT: chan_done=1 -> DECODE. Timer reaches TIMEOUT without chan_done -> RETRY.
//    chan_done and timeout in the same cycle: chan_done wins.
//  DECODE: wait DEC_LAT cycles, then sample the flags.
//    err_fatal=1 -> RETRY.
//    Otherwise -> DELIVER, and corr_cnt++ if err_corrected=1. err_fatal has priority over err_corrected.
//  RETRY (a transition, not a state): retry_cnt<MAX_RETRY -> retry_cnt++ and -> ENCODE (datapath holds the char).
//    Otherwise -> FAIL.
//  DELIVER: sink_valid=1 until handshake. On handshake: latched last=1 -> DONE, else -> FETCH. Back-to-back chars allowed.
//  DONE / FAIL: done / link_fail=1, busy=0. Both hold until enable=0, then -> IDLE (flags cleared).
//  enable=0 in KEYLOAD..DECODE: -> IDLE next cycle; init_done cleared; any pending strobe is suppressed.
//  enable=0 in DELIVER: keep sink_valid until handshake, then -> IDLE. No valid is dropped.
//  Latency, clean character, sink_ready=1: 1 + ENC_LAT + 1 + channel + DEC_LAT + 1 cycles, FETCH accept to handshake.
//  Timer width: $clog2(TIMEOUT+1). Timer saturates and never wraps.
// CONFIGURATION
//  TEXT_LINK_CTRL_STATS_EN defined:
//    Adds outputs char_cnt, corr_cnt, retry_tot, each CNT_W bits.
//    char_cnt = sink handshakes; corr_cnt = corrected chars; retry_tot = all retries.
//    Counters saturate at all-ones and clear on reset or IDLE entry.
//  Undefined: these ports and counters are absent; control behaviour is identical.
// TESTING
//  1 Reset low mid-XMIT -> all outputs 0, state_o=0 in the same cycle. Release with enable=1 -> key_ld pulse, key=123.
//  2 3-char message, no errors, sink_ready=1, chan_done 4 cycles after tx_start -> 3 tx_start, 3 sink handshakes, done=1.
//    Each handshake occurs exactly 1+2+1+4+2+1 cycles after its src accept.
//  3 err_fatal=1 on the first two decodes of char 0 -> 3 tx_start for char 0, then delivery.
//    With STATS: retry_tot=2, link_fail=0.
//  4 chan_done withheld -> (MAX_RETRY+1)=4 timeouts of TIMEOUT cycles, then link_fail=1 and busy=0. Hold until enable=0 -> IDLE.
//  5 crypto_ready never asserted -> FAIL after 255 cycles, init_done stays 0.
//  6 sink_ready=0 for 10 cycles while enable drops in DELIVER -> sink_valid held; handshake; then IDLE, init_done=0.
//  7 err_corrected=1 on every decode of a 4-char message -> delivered normally; corr_cnt=4, char_cnt=4 (STATS build).

Source files
------------

// File: rtl/text_link_ctrl.sv
// text_link_ctrl: control sequencer for the text link chain
// (source -> compress -> encrypt -> Hamming -> BPSK -> channel -> decode ... -> sink).
// Drives control pins only. Loads the cipher key, moves one character per frame,
// retransmits on fatal decode errors or channel timeouts, and hands each char to the sink.
// Optional statistics outputs (char_cnt, corr_cnt, retry_tot): define TEXT_LINK_CTRL_STATS_EN.
module text_link_ctrl #(
  parameter logic [7:0] KEY       = 8'd123,
  parameter int         ENC_LAT   = 2,
  parameter int         DEC_LAT   = 2,
  parameter int         TIMEOUT   = 255,
  parameter int         MAX_RETRY = 3,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [7:0]       key,
  output logic             key_ld,
  input  logic             crypto_ready,
  output logic             init_done,
  output logic             src_req,
  input  logic             src_valid,
  input  logic             src_last,
  output logic             tx_start,
  input  logic             chan_done,
  input  logic             err_corrected,
  input  logic             err_fatal,
  output logic             sink_valid,
  input  logic             sink_ready,
  output logic             busy,
  output logic             done,
  output logic             link_fail,
  output logic [3:0]       state_o
`ifdef TEXT_LINK_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] char_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] retry_tot
`endif
);

  // One shared timer serves every waiting state; size it for the longest wait.
  localparam int TMAX = (TIMEOUT >= ENC_LAT && TIMEOUT >= DEC_LAT) ? TIMEOUT :
                        ((ENC_LAT >= DEC_LAT) ? ENC_LAT : DEC_LAT);
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Timer compare points: KEYLOAD/XMIT occupy TIMEOUT cycles, ENCODE ENC_LAT cycles.
  // DECODE samples the flags one cycle after they become valid (DEC_LAT after chan_done).
  localparam logic [TW-1:0] T_TO  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ENC = TW'(ENC_LAT - 1);
  localparam logic [TW-1:0] T_DEC = TW'(DEC_LAT);
  localparam logic [TW-1:0] T_SAT = TW'(TMAX);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_KEYLOAD = 4'd1,
    ST_FETCH   = 4'd2,
    ST_ENCODE  = 4'd3,
    ST_XMIT    = 4'd4,
    ST_DECODE  = 4'd5,
    ST_DELIVER = 4'd6,
    ST_DONE    = 4'd7,
    ST_FAIL    = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            last_q, last_d;
  logic            init_q, init_d;
  logic            retry_req;

  // State register and control flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      last_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      last_q  <= last_d;
      init_q  <= init_d;
    end
  end

  // Next-state: enable low aborts active states except DELIVER, which finishes its handshake
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
    retry_d   = retry_q;
    last_d    = last_q;
    init_d    = init_q;
    retry_req = 1'b0;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_KEYLOAD;
      ST_KEYLOAD: begin
        if (!enable)                state_d = ST_IDLE;
        else if (crypto_ready) begin
          state_d = ST_FETCH;
          init_d  = 1'b1;
        end else if (timer_q == T_TO) state_d = ST_FAIL;
      end
      ST_FETCH: begin
        if (!enable) state_d = ST_IDLE;
        else if (src_valid) begin
          last_d  = src_last;
          retry_d = '0;
          state_d = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        if (!enable)                 state_d = ST_IDLE;
        else if (timer_q == T_ENC)   state_d = ST_XMIT;
      end
      ST_XMIT: begin
        if (!enable)                 state_d = ST_IDLE;
        else if (chan_done)          state_d = ST_DECODE;
        else if (timer_q == T_TO)    retry_req = 1'b1;
      end
      ST_DECODE: begin
        if (!enable)                 state_d = ST_IDLE;
        else if (timer_q == T_DEC) begin
          if (err_fatal) retry_req = 1'b1;
          else           state_d   = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (sink_ready) begin
          if (!enable)     state_d = ST_IDLE;
          else if (last_q) state_d = ST_DONE;
          else             state_d = ST_FETCH;
        end
      end
      ST_DONE, ST_FAIL: if (!enable) state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
    // Retransmit: the datapath still holds the character, so go straight back to ENCODE
    if (retry_req) begin
      if (retry_q < R_MAX) begin
        retry_d = retry_q + 1'b1;
        state_d = ST_ENCODE;
      end else begin
        state_d = ST_FAIL;
      end
    end
    if (state_d != state_q) timer_d = '0;
    if (state_d == ST_IDLE) init_d  = 1'b0;
  end

  // Outputs: strobes fire on state entry (timer at 0) and are suppressed while enable is low
  always_comb begin
    key_ld     = (state_q == ST_KEYLOAD) && (timer_q == '0) && enable;
    key        = key_ld ? KEY : 8'd0;
    src_req    = (state_q == ST_FETCH) && enable;
    tx_start   = (state_q == ST_XMIT) && (timer_q == '0) && enable;
    sink_valid = (state_q == ST_DELIVER);
    busy       = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL));
    done       = (state_q == ST_DONE);
    link_fail  = (state_q == ST_FAIL);
    init_done  = init_q;
    state_o    = state_q;
  end

`ifdef TEXT_LINK_CTRL_STATS_EN
  logic [CNT_W-1:0] char_cnt_q, char_cnt_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] retry_tot_q, retry_tot_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Statistics: saturating counts, cleared on IDLE entry; events derived from transitions
  always_comb begin
    char_cnt_d  = char_cnt_q;
    corr_cnt_d  = corr_cnt_q;
    retry_tot_d = retry_tot_q;
    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      char_cnt_d  = '0;
      corr_cnt_d  = '0;
      retry_tot_d = '0;
    end else begin
      if (sink_valid && sink_ready)
        char_cnt_d = sat_inc(char_cnt_q);
      if (state_q == ST_DECODE && state_d == ST_DELIVER && err_corrected)
        corr_cnt_d = sat_inc(corr_cnt_q);
      if ((state_q == ST_XMIT || state_q == ST_DECODE) && state_d == ST_ENCODE)
        retry_tot_d = sat_inc(retry_tot_q);
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_cnt_q  <= '0;
      corr_cnt_q  <= '0;
      retry_tot_q <= '0;
    end else begin
      char_cnt_q  <= char_cnt_d;
      corr_cnt_q  <= corr_cnt_d;
      retry_tot_q <= retry_tot_d;
    end
  end

  assign char_cnt  = char_cnt_q;
  assign corr_cnt  = corr_cnt_q;
  assign retry_tot = retry_tot_q;
`endif

endmodule

// File: tb/tb_text_link_ctrl.sv
// Directed bench for text_link_ctrl with source/channel/decoder models and a
// handshake-timing scoreboard (expected handshake cycle pushed at src accept).
module tb_text_link_ctrl;
  localparam int ENC  = 2;
  localparam int DEC  = 2;
  localparam int CH   = 4;
  localparam int LAT  = 1 + ENC + 1 + CH + DEC + 1;  // accept -> handshake, clean char
  localparam int RLAT = ENC + 1 + CH + DEC + 1;      // extra cycles per retransmission

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, crypto_ready = 1'b0, src_valid = 1'b0, src_last = 1'b0;
  logic chan_done = 1'b0, err_corrected = 1'b0, err_fatal = 1'b0, sink_ready = 1'b0;
  logic [7:0] key;
  logic key_ld, init_done, src_req, tx_start, sink_valid, busy, done, link_fail;
  logic [3:0] state_o;
`ifdef TEXT_LINK_CTRL_STATS_EN
  logic [15:0] char_cnt, corr_cnt, retry_tot;
`endif

  text_link_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .key(key), .key_ld(key_ld),
    .crypto_ready(crypto_ready), .init_done(init_done), .src_req(src_req),
    .src_valid(src_valid), .src_last(src_last), .tx_start(tx_start),
    .chan_done(chan_done), .err_corrected(err_corrected), .err_fatal(err_fatal),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .busy(busy), .done(done),
    .link_fail(link_fail), .state_o(state_o)
`ifdef TEXT_LINK_CTRL_STATS_EN
    , .char_cnt(char_cnt), .corr_cnt(corr_cnt), .retry_tot(retry_tot)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  int tx_n, hs_n, kld_n, kl_n, msg_left, fatal_left, chan_at;
  bit init_seen, chan_en, corr_all, lat_chk;
  int sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observe one cycle mid-period, then update the environment models after the edge
  task automatic tick();
    int e;
    @(negedge clk);
    cyc++;
    if (key_ld) begin kld_n++; chk("key_val", key, 123); end
    if (tx_start) begin tx_n++; chan_at = cyc + CH; end
    if (state_o == 4'd1) kl_n++;
    if (init_done) init_seen = 1'b1;
    if (src_req && src_valid) begin
      sb.push_back(lat_chk ? cyc + LAT + RLAT * fatal_left : -1);
      msg_left--;
    end
    if (sink_valid && sink_ready) begin
      hs_n++;
      chk("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e >= 0) chk("hs_cycle", cyc, e);
      end
    end
    @(posedge clk); #1;
    src_valid = msg_left > 0;
    src_last  = msg_left == 1;
    chan_done = chan_en && (cyc + 1 == chan_at);
    if (chan_done) begin
      err_fatal = fatal_left > 0;
      if (fatal_left > 0) fatal_left--;
      err_corrected = corr_all;
    end
  endtask

  task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
    for (int i = 0; i < budget && state_o !== code; i++) tick();
    chk(tag, state_o, code);
  endtask

  task automatic start(input int msg, input int fatal, input bit corr, input bit chen,
                       input bit rdy, input bit cr, input bit lat);
    sb.delete();
    tx_n = 0; hs_n = 0; kld_n = 0; kl_n = 0; init_seen = 1'b0; chan_at = -1;
    msg_left = msg; fatal_left = fatal; corr_all = corr; chan_en = chen; lat_chk = lat;
    sink_ready = rdy; crypto_ready = cr;
    src_valid = msg > 0; src_last = msg == 1;
    chan_done = 1'b0; err_fatal = 1'b0; err_corrected = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_key", key, 0);
    chk("rst_outs", {key_ld, init_done, src_req, tx_start, sink_valid, busy, done, link_fail}, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 3-char clean message with latency scoreboard
    start(3, 0, 0, 1, 1, 1, 1);
    wait_state("t2_done", 4'd7, 200);
    chk("t2_tx", tx_n, 3);
    chk("t2_hs", hs_n, 3);
    chk("t2_kld", kld_n, 1);
    chk("t2_flags", {done, busy, link_fail, init_done}, 4'b1001);
    chk("t2_sb_empty", sb.size(), 0);
`ifdef TEXT_LINK_CTRL_STATS_EN
    chk("t2_char_cnt", char_cnt, 3);
`endif
    enable = 1'b0;
    tick();
    chk("t2_idle", {state_o, done, init_done}, 0);

    // 4-char message, every decode corrected
    start(4, 0, 1, 1, 1, 1, 1);
    wait_state("t7_done", 4'd7, 200);
    chk("t7_hs", hs_n, 4);
    chk("t7_tx", tx_n, 4);
`ifdef TEXT_LINK_CTRL_STATS_EN
    chk("t7_corr_cnt", corr_cnt, 4);
    chk("t7_char_cnt", char_cnt, 4);
`endif
    enable = 1'b0;
    tick();

    // Two fatal decodes on char 0 -> two retransmissions then delivery
    start(1, 2, 0, 1, 1, 1, 1);
    wait_state("t3_done", 4'd7, 200);
    chk("t3_tx", tx_n, 3);
    chk("t3_hs", hs_n, 1);
    chk("t3_fail", link_fail, 0);
`ifdef TEXT_LINK_CTRL_STATS_EN
    chk("t3_retry_tot", retry_tot, 2);
`endif
    enable = 1'b0;
    tick();

    // enable drops while sink stalls in DELIVER
    start(1, 0, 0, 1, 0, 1, 0);
    wait_state("t6_deliver", 4'd6, 100);
    enable = 1'b0;
    repeat (10) tick();
    chk("t6_hold", {state_o, sink_valid}, {4'd6, 1'b1});
    sink_ready = 1'b1;
    tick();
    chk("t6_hs", hs_n, 1);
    chk("t6_idle", {state_o, init_done, done}, 0);

    // enable drops in ENCODE -> IDLE, no tx_start
    start(1, 0, 0, 1, 1, 1, 1);
    wait_state("abort_enc", 4'd3, 50);
    enable = 1'b0;
    tick();
    tick();
    chk("abort_idle", {state_o, init_done}, 0);
    chk("abort_no_tx", tx_n, 0);

    // Channel never answers -> 4 transmissions, then FAIL held until enable low
    start(1, 0, 0, 0, 1, 1, 1);
    wait_state("t4_fail", 4'd8, 1500);
    chk("t4_tx", tx_n, 4);
    chk("t4_flags", {link_fail, busy, done}, 3'b100);
    chk("t4_hs", hs_n, 0);
`ifdef TEXT_LINK_CTRL_STATS_EN
    chk("t4_retry_tot", retry_tot, 3);
`endif
    repeat (5) tick();
    chk("t4_hold", {state_o, link_fail}, {4'd8, 1'b1});
    enable = 1'b0;
    tick();
    chk("t4_idle", {state_o, link_fail}, 0);

    // crypto_ready never asserted -> FAIL after TIMEOUT cycles in KEYLOAD
    start(1, 0, 0, 1, 1, 0, 1);
    wait_state("t5_fail", 4'd8, 400);
    chk("t5_kl_cycles", kl_n, 255);
    chk("t5_init_seen", init_seen, 0);
    chk("t5_link_fail", link_fail, 1);
    enable = 1'b0;
    tick();

    // Reset mid-XMIT clears everything at once; restart gives a key pulse
    start(1, 0, 0, 0, 1, 1, 1);
    wait_state("t1_xmit", 4'd4, 50);
    tick();
    chk("t1_busy", {state_o, busy}, {4'd4, 1'b1});
    reset = 1'b0;
    #2;
    chk("t1_rst_state", state_o, 0);
    chk("t1_rst_outs", {key, key_ld, init_done, src_req, tx_start, sink_valid, busy, done, link_fail}, 0);
    @(posedge clk); #1;
    kld_n = 0;
    reset = 1'b1;
    repeat (3) tick();
    chk("t1_kld", kld_n, 1);
    chk("t1_init", init_done, 1);
    enable = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
